updown_counter_ssd: RTL and testbench

Parametrised up/down counter with prescaled count enable, synchronous load, terminal-count pulse and a time-multiplexed DIGITS-digit active-low seven-segment driver. It replaces the single-digit, 4-bit board counter. The full count value is shown in hex across the board's digits, and the raw count is exported on `q` for the LEDs.

---
 rtl/ssd_pkg.sv | 25 ++
 rtl/hex_to_ssd.sv | 32 +++
 rtl/updown_counter_ssd.sv | 113 +++++++++++
 tb/tb_updown_counter_ssd.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - segment type and active-low hex glyph constants (a..g = bit 6..0)
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

endpackage

// File: rtl/hex_to_ssd.sv
// rtl/hex_to_ssd.sv - combinational nibble to active-low seven-segment decoder
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/updown_counter_ssd.sv
// rtl/updown_counter_ssd.sv - prescaled up/down counter with load, wrap pulse and
// time-multiplexed hex seven-segment display of the full count
module updown_counter_ssd
  import ssd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1,
  parameter int REFRESH  = 100000,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic [DIGITS-1:0]     an,
  output seg_t                  seg
);

  localparam int W   = 4 * DIGITS;
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RCW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PCW-1:0]    PC_LAST  = PCW'(PRESCALE - 1);
  localparam logic [PCW-1:0]    PC_ONE   = PCW'(1);
  localparam logic [RCW-1:0]    RC_LAST  = RCW'(REFRESH - 1);
  localparam logic [RCW-1:0]    RC_ONE   = RCW'(1);
  localparam logic [SW-1:0]     SEL_LAST = SW'(DIGITS - 1);
  localparam logic [SW-1:0]     SEL_ONE  = SW'(1);
  localparam logic [W-1:0]      Q_ONE    = W'(1);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

  logic [PCW-1:0]    r_pc;
  logic [W-1:0]      r_q;
  logic [RCW-1:0]    r_rc;
  logic [SW-1:0]     r_sel;
  logic [DIGITS-1:0] r_an;
  seg_t              r_seg;

  logic              w_step;
  logic              w_rc_wrap;
  logic [SW+1:0]     w_shift;
  logic [W-1:0]      w_upper;
  logic [3:0]        w_nib;
  seg_t              w_dec;
  logic              w_blank;

  assign w_step    = en && (r_pc == PC_LAST);
  assign w_rc_wrap = (r_rc == RC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (en) begin
      r_pc <= w_step ? '0 : r_pc + PC_ONE;
    end
  end

  // load outranks a step; the prescaler keeps running regardless of load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= din;
    end else if (w_step) begin
      r_q <= up ? r_q + Q_ONE : r_q - Q_ONE;
    end
  end

  assign tc = w_step && !load && (up ? (r_q == '1) : (r_q == '0));
  assign q  = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rc  <= '0;
      r_sel <= '0;
    end else begin
      r_rc <= w_rc_wrap ? '0 : r_rc + RC_ONE;
      if (w_rc_wrap) begin
        r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_ONE;
      end
    end
  end

  assign w_shift = {r_sel, 2'b00};
  assign w_upper = r_q >> w_shift;
  assign w_nib   = w_upper[3:0];
  assign w_blank = (BLANK_LZ != 0) && (r_sel != '0) && (w_upper == '0);

  hex_to_ssd u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // an and seg share one register stage so a digit switch never shows a stale pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= ~AN_ONE;
      r_seg <= SEG_0;
    end else begin
      r_an  <= ~(AN_ONE << r_sel);
      r_seg <= w_blank ? SEG_BLANK : w_dec;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_updown_counter_ssd.sv
// tb/tb_updown_counter_ssd.sv - scoreboard bench: unit A (PRESCALE=1) and unit B
// (PRESCALE=3, BLANK_LZ=1), both REFRESH=2, against a cycle model
module tb_updown_counter_ssd;

  logic        clk;
  logic        rst;
  logic        en_a, up_a, ld_a, en_b, up_b, ld_b;
  logic [15:0] din_a, din_b, q_a, q_b;
  logic        tc_a, tc_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  updown_counter_ssd #(.DIGITS(4), .PRESCALE(1), .REFRESH(2), .BLANK_LZ(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(ld_a), .din(din_a),
    .q(q_a), .tc(tc_a), .an(an_a), .seg(seg_a)
  );

  updown_counter_ssd #(.DIGITS(4), .PRESCALE(3), .REFRESH(2), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(ld_b), .din(din_b),
    .q(q_b), .tc(tc_b), .an(an_b), .seg(seg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    int          pc;
    int          rc;
    int          sel;
  } st_t;

  typedef struct {
    logic [15:0] q;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  st_t  st_a, st_b;
  exp_t exq [$];
  int   n_chk;
  int   n_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic st_t st_reset();
    st_t s;
    s.q = 16'h0000; s.pc = 0; s.rc = 0; s.sel = 0;
    return s;
  endfunction

  function automatic logic is_step(st_t s, logic en, int p);
    return en && (s.pc == p - 1);
  endfunction

  function automatic st_t model_next(st_t s, logic en, logic up, logic ld, logic [15:0] din, int p, int r);
    st_t n;
    logic stp;
    n   = s;
    stp = is_step(s, en, p);
    if (ld) n.q = din;
    else if (stp) n.q = up ? s.q + 16'h1 : s.q - 16'h1;
    if (en) n.pc = stp ? 0 : s.pc + 1;
    if (s.rc == r - 1) begin
      n.rc  = 0;
      n.sel = (s.sel == 3) ? 0 : s.sel + 1;
    end else begin
      n.rc = s.rc + 1;
    end
    return n;
  endfunction

  function automatic logic model_tc(st_t s, logic en, logic up, logic ld, int p);
    return is_step(s, en, p) && !ld && (up ? (s.q == 16'hFFFF) : (s.q == 16'h0000));
  endfunction

  function automatic logic [3:0] model_an(st_t s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s.sel);
  endfunction

  function automatic logic [6:0] model_seg(st_t s, int blz);
    logic [15:0] upper;
    upper = s.q >> (4 * s.sel);
    if (blz != 0 && s.sel > 0 && upper == 16'h0000) return 7'b1111111;
    return hex_tab[upper[3:0]];
  endfunction

  // one clock: check combinational tc, push post-edge expectations, pop after the edge
  task automatic tick();
    st_t  na, nb;
    exp_t e;
    #1;
    check_eq("tc_a", {31'b0, tc_a}, {31'b0, model_tc(st_a, en_a, up_a, ld_a, 1)});
    check_eq("tc_b", {31'b0, tc_b}, {31'b0, model_tc(st_b, en_b, up_b, ld_b, 3)});
    na = model_next(st_a, en_a, up_a, ld_a, din_a, 1, 2);
    nb = model_next(st_b, en_b, up_b, ld_b, din_b, 3, 2);
    exq.push_back('{na.q, model_an(st_a), model_seg(st_a, 0)});
    exq.push_back('{nb.q, model_an(st_b), model_seg(st_b, 1)});
    st_a = na;
    st_b = nb;
    @(posedge clk);
    #2;
    if (exq.size() < 2) begin
      check_eq("sb_underflow", 32'(exq.size()), 32'd2);
    end else begin
      e = exq.pop_front();
      check_eq("q_a", {16'b0, q_a}, {16'b0, e.q});
      check_eq("an_a", {28'b0, an_a}, {28'b0, e.an});
      check_eq("seg_a", {25'b0, seg_a}, {25'b0, e.seg});
      e = exq.pop_front();
      check_eq("q_b", {16'b0, q_b}, {16'b0, e.q});
      check_eq("an_b", {28'b0, an_b}, {28'b0, e.an});
      check_eq("seg_b", {25'b0, seg_b}, {25'b0, e.seg});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_q_a"}, {16'b0, q_a}, 32'h0);
    check_eq({tag, "_an_a"}, {28'b0, an_a}, 32'b1110);
    check_eq({tag, "_seg_a"}, {25'b0, seg_a}, 32'b0000001);
    check_eq({tag, "_tc_a"}, {31'b0, tc_a}, 32'h0);
    check_eq({tag, "_q_b"}, {16'b0, q_b}, 32'h0);
    check_eq({tag, "_an_b"}, {28'b0, an_b}, 32'b1110);
    check_eq({tag, "_seg_b"}, {25'b0, seg_b}, 32'b0000001);
    check_eq({tag, "_tc_b"}, {31'b0, tc_b}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    en_a = 1'b0; up_a = 1'b1; ld_a = 1'b0; din_a = 16'h0;
    en_b = 1'b0; up_b = 1'b1; ld_b = 1'b0; din_b = 16'h0;
    st_a = st_reset();
    st_b = st_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // up-count on A, down-wrap with prescale on B
    en_a = 1'b1; up_a = 1'b1;
    en_b = 1'b1; up_b = 1'b0;
    repeat (3) tick();
    check_eq("b_down_wrap", {16'b0, q_b}, 32'h0000FFFF);
    check_eq("a_count3", {16'b0, q_a}, 32'h3);
    en_b = 1'b0;
    repeat (5) tick();
    check_eq("b_frozen", {16'b0, q_b}, 32'h0000FFFF);

    // A wraps FFFF -> 0000
    ld_a = 1'b1; din_a = 16'hFFFD;
    tick();
    ld_a = 1'b0;
    check_eq("a_load_fffd", {16'b0, q_a}, 32'h0000FFFD);
    repeat (4) tick();
    check_eq("a_after_wrap", {16'b0, q_a}, 32'h1);

    // load coincides with a step on both units
    en_b = 1'b1; up_b = 1'b1;
    ld_a = 1'b1; din_a = 16'h1234;
    ld_b = 1'b1; din_b = 16'h4321;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
    check_eq("a_load_wins", {16'b0, q_a}, 32'h1234);
    tick();
    check_eq("a_step_after_load", {16'b0, q_a}, 32'h1235);
    up_a = 1'b0;
    tick();
    check_eq("a_dir_change", {16'b0, q_a}, 32'h1234);
    repeat (4) tick();

    // scan A5C3 on A, leading-zero blanking of 0007 on B
    en_a = 1'b0; en_b = 1'b0;
    ld_a = 1'b1; din_a = 16'hA5C3;
    ld_b = 1'b1; din_b = 16'h0007;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
    repeat (12) tick();

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      en_a = 1'($urandom_range(0, 1)); up_a = 1'($urandom_range(0, 1));
      ld_a = ($urandom_range(0, 9) == 0); din_a = 16'($urandom);
      en_b = 1'($urandom_range(0, 1)); up_b = 1'($urandom_range(0, 1));
      ld_b = ($urandom_range(0, 9) == 0); din_b = 16'($urandom);
      if (i % 50 == 0) begin
        din_a = (i % 100 == 0) ? 16'hFFFF : 16'h0000;
        din_b = din_a;
      end
      tick();
    end

    // async reset mid-scan
    en_a = 1'b1; up_a = 1'b1; ld_a = 1'b1; din_a = 16'hBEEF;
    en_b = 1'b1; up_b = 1'b1; ld_b = 1'b1; din_b = 16'h00C0;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
    repeat (3) tick();
    en_a = 1'b0; en_b = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    st_a = st_reset();
    st_b = st_reset();
    en_a = 1'b1; up_a = 1'b1;
    en_b = 1'b1; up_b = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
